// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues one outstanding imem request at a time, and presents
// a fetched word (or NOP bubble) with its PC to the fetch/decode register.
module fetch_stage #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic                     imem_req_o,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic                     imem_ack_i,
  input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
  output logic [DATA_WIDTH-1:0]    instr_o,
  output logic [ADDRESS_WIDTH-1:0] pc_o,
  output logic [ADDRESS_WIDTH-1:0] pc_inced_o,
  output logic                     valid_o
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic                     kill_q;
  logic [DATA_WIDTH-1:0]    buf_q;
  logic                     req_q;
  logic                     valid_q;
  logic [ADDRESS_WIDTH-1:0] redirect_tgt;

  // Targets are word aligned; the low two bits of the redirect address are dropped.
  assign redirect_tgt = redirect_pc_i & ~ADDRESS_WIDTH'(3);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      buf_q   <= NOP;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          state_q <= S_WAIT;
          req_q   <= 1'b0;
          if (redirect_i) begin
            pc_q   <= redirect_tgt;
            kill_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (redirect_i) pc_q <= redirect_tgt;
          if (imem_ack_i) begin
            // A response overtaken by any redirect is stale and never reaches decode.
            if (kill_q || redirect_i) begin
              kill_q  <= 1'b0;
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end else begin
              buf_q   <= imem_rdata_i;
              state_q <= S_HOLD;
              valid_q <= 1'b1;
            end
          end else if (redirect_i) begin
            kill_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_i) begin
            pc_q    <= redirect_tgt;
            state_q <= S_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end else if (!stall_i) begin
            pc_q    <= pc_q + ADDRESS_WIDTH'(4);
            state_q <= S_REQ;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_BOOT;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign valid_o     = valid_q;
  assign instr_o     = valid_q ? buf_q : NOP;
  assign pc_o        = pc_q;
  assign pc_inced_o  = pc_q + ADDRESS_WIDTH'(4);

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level fetch/memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i, stall_i, redirect_i, imem_ack_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, valid_o;
  logic [31:0] imem_addr_o, instr_o, pc_o, pc_inced_o;

  logic        ack2;
  logic [31:0] rdata2;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, inc2;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .instr_o(instr_o),
    .pc_o(pc_o), .pc_inced_o(pc_inced_o), .valid_o(valid_o)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst_i), .stall_i(1'b0), .redirect_i(1'b0),
    .redirect_pc_i(32'h0), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_rdata_i(rdata2), .instr_o(instr2),
    .pc_o(pc2), .pc_inced_o(inc2), .valid_o(valid2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  // Model: what the next request address is, and whether a request / valid word is due now.
  bit          exp_req, exp_valid, outstanding, stale;
  logic [31:0] exp_fetch, out_addr;
  int          cnt;
  int          p_stall, p_redir, max_lat;
  bit          prev_req2, wrap_seen;
  logic [31:0] prev_addr2;
  int          req2_n;

  task automatic reset_seq();
    @(posedge clk);
    #2;
    rst_i = 1'b1; stall_i = 0; redirect_i = 0; imem_ack_i = 0; ack2 = 0;
    #1;
    chk("rst_req", imem_req_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_instr", instr_o, NOP);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_inced", pc_inced_o, 32'h4);
    chk("wrap_rst_inced", inc2, 32'h0);
    @(negedge clk);
    chk("boot_req", imem_req_o, 0);
    rst_i = 1'b0;
    outstanding = 0; stale = 0; exp_valid = 0; exp_req = 1; exp_fetch = 32'h0;
    prev_req2 = 0; req2_n = 0; wrap_seen = 0;
  endtask

  task automatic do_cycle();
    bit nreq, nvalid;
    @(negedge clk);
    chk("req", imem_req_o, exp_req);
    chk("valid", valid_o, exp_valid);
    if (exp_req) chk("addr", imem_addr_o, exp_fetch);
    if (exp_valid) begin
      chk("pc", pc_o, exp_fetch);
      chk("instr", instr_o, memf(exp_fetch));
      chk("inced", pc_inced_o, exp_fetch + 32'd4);
    end else begin
      chk("nop", instr_o, NOP);
    end

    if (req2) begin
      if (req2_n == 0) chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
      else if (req2_n == 1) chk("wrap_addr1", addr2, 32'h0);
      req2_n++;
    end
    if (valid2 && !wrap_seen) begin
      wrap_seen = 1;
      chk("wrap_pc", pc2, 32'hFFFF_FFFC);
      chk("wrap_inced", inc2, 32'h0);
    end
    ack2 = prev_req2;
    rdata2 = memf(prev_addr2);
    prev_req2 = req2;
    prev_addr2 = addr2;

    stall_i = ($urandom_range(0, 99) < p_stall);
    redirect_i = (exp_req || exp_valid || outstanding) && ($urandom_range(0, 99) < p_redir);
    redirect_pc_i = $urandom();
    imem_ack_i = 1'b0;
    imem_rdata_i = $urandom();
    if (outstanding) begin
      if (cnt <= 1) begin
        imem_ack_i = 1'b1;
        imem_rdata_i = memf(out_addr);
      end else begin
        cnt--;
      end
    end

    nreq = 0; nvalid = 0;
    if (exp_req) begin
      outstanding = 1; stale = redirect_i; out_addr = exp_fetch;
      cnt = $urandom_range(1, max_lat);
    end else if (outstanding) begin
      if (imem_ack_i) begin
        if (stale || redirect_i) nreq = 1; else nvalid = 1;
        outstanding = 0; stale = 0;
      end else if (redirect_i) begin
        stale = 1;
      end
    end
    if (exp_valid) begin
      if (redirect_i) nreq = 1;
      else if (stall_i) nvalid = 1;
      else begin nreq = 1; exp_fetch = exp_fetch + 32'd4; end
    end
    if (redirect_i) exp_fetch = redirect_pc_i & ~32'd3;
    exp_req = nreq;
    exp_valid = nvalid;
  endtask

  initial begin
    rst_i = 0; stall_i = 0; redirect_i = 0; redirect_pc_i = 0;
    imem_ack_i = 0; imem_rdata_i = 0; ack2 = 0; rdata2 = 0;
    prev_addr2 = 0;
    reset_seq();
    p_stall = 0; p_redir = 0; max_lat = 1;
    repeat (15) do_cycle();
    p_stall = 30; p_redir = 10; max_lat = 4;
    repeat (2000) do_cycle();
    reset_seq();
    p_stall = 50; p_redir = 25; max_lat = 2;
    repeat (2000) do_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the program counter, issues one-outstanding instruction-memory requests, and presents a fetched instruction with its incremented PC to the fetch→decode pipeline register. Sits directly upstream of the fetch/decode pipeline register. Accepts stall from the hazard unit and PC redirects from execute. Emits a NOP (0x00000013) whenever no valid instruction is held, so the downstream register sees bubbles.

## Interface
- ADDRESS_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC loaded on reset
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  downstream stalled; hold the presented instruction
- redirect_i  in  1  branch/jump taken; replace PC
- redirect_pc_i  in  ADDRESS_WIDTH  redirect target; bits [1:0] ignored (forced 0)
- imem_req_o  out  1  request for word at imem_addr_o, asserted exactly in REQ state
- imem_addr_o  out  ADDRESS_WIDTH  = pc
- imem_ack_i  in  1  response valid, at least 1 cycle after the request
- imem_rdata_i  in  DATA_WIDTH  instruction word, valid with imem_ack_i
- instr_o  out  DATA_WIDTH  held instruction in HOLD, else 32'h0000_0013
- pc_o  out  ADDRESS_WIDTH  PC of instr_o
- pc_inced_o  out  ADDRESS_WIDTH  pc_o + 4, modulo 2^ADDRESS_WIDTH
- valid_o  out  1  high only in HOLD

## Operation
- Registers: pc, state {BOOT, REQ, WAIT, HOLD}, kill flag, instruction buffer.
- Memory: always accepts a request in the cycle imem_req_o is high; at most one request outstanding; ack outside WAIT is ignored.
- BOOT: imem_req_o=0; next state REQ unconditionally.
- REQ: imem_req_o=1, imem_addr_o=pc; next state WAIT. If redirect_i: pc <= {redirect_pc_i[31:2],2'b00}, kill <= 1 (the issued request is still completed and discarded).
- WAIT: on redirect_i, pc <= target, kill <= 1. On imem_ack_i:
  - kill=1 or redirect_i same cycle: drop data, kill <= 0, next REQ.
  - else: buffer <= imem_rdata_i, next HOLD.
- HOLD: valid_o=1, instr_o=buffer.
  - redirect_i (priority over stall_i): pc <= target, next REQ.
  - else stall_i: remain, all outputs stable.
  - else: pc <= pc + 4 (wraps), next REQ.
- stall_i has no effect outside HOLD.
- pc_inced_o is combinational from pc; no carry-out.

## Timing
- Reset (async, immediate): state=BOOT, pc=RESET_PC, kill=0, buffer=0x0000_0013; outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_o=0x0000_0013, valid_o=0, pc_o=RESET_PC, pc_inced_o=RESET_PC+4.
- Reset mid-transaction: any outstanding response is ignored. The environment does not ack after reset without a new request.
- With 1-cycle memory (ack the cycle after REQ): REQ(c0) → WAIT+ack(c1) → HOLD(c2, valid_o=1) → REQ(c3) when not stalled. Throughput is 1 instruction / 3 cycles. Each extra wait cycle adds one cycle.
- Redirect latency: target appears on imem_addr_o 1 cycle after redirect_i from HOLD. From REQ/WAIT, it appears 1 cycle after the stale ack is dropped.
- Redirect and ack in the same WAIT cycle: data discarded, next cycle REQ at target.
- Redirect and stall in the same HOLD cycle: redirect wins.
- Redirect in consecutive cycles: the last target wins; kill stays set until the single outstanding ack is dropped.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle → instr_o=0x13, valid_o=0, imem_req_o=0 immediately. After release: BOOT, then REQ with imem_addr_o=RESET_PC.
- Sequential fetch, 1-cycle memory returning 0xA0000000+addr: valid_o on c2, c5, c8 with pc_o=0,4,8, pc_inced_o=4,8,12, instr_o matching.
- Stall: hold stall_i 4 cycles in HOLD at pc=8 → instr_o/pc_o constant, imem_req_o=0. After release: next REQ at 12.
- Redirect in HOLD at pc=4 to 0x103 → next REQ addr 0x100. Fetched word appears with pc_o=0x100, pc_inced_o=0x104.
- Redirect in WAIT to 0x40 with ack 3 cycles later (data 0xDEAD) → 0xDEAD never on instr_o, valid_o stays 0, next REQ addr 0x40. Repeat with ack coincident with redirect.
- Wrap: RESET_PC=32'hFFFF_FFFC → pc_inced_o=0. After consuming: next REQ addr 0x0.
